// File: rtl/mem_stage_sram.sv
// mem_stage_sram: MEM stage of the ARM pipeline. It sits between EXE and WB,
// holds a word-addressed data SRAM with a fixed number of wait states, and
// produces the MEM/WB pipeline register. The ready output tells the top level
// when the upstream stages have to freeze while an access is in flight.
module mem_stage_sram #(
   parameter int ADDR_BASE   = 1024,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        wb_en_in,
   input  logic [3:0]  dest_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] val_rm_in,
   output logic        ready,
   output logic        wb_en_out,
   output logic        mem_read_out,
   output logic [3:0]  dest_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] mem_data_out,
   output logic        addr_error_out
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [31:0] BASE_ADDR   = 32'(ADDR_BASE);
   localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } stateT;

   stateT            state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      memArray [DEPTH];

   logic             memReq;
   logic             isLoad;
   logic             accessIllegal;
   logic [31:0]      wordIdx;
   logic [IDX_W-1:0] memIdx;
   logic [31:0]      readData_d;

   // A store wins when both read and write are requested, so a load is a read without a write.
   assign memReq  = mem_read_in | mem_write_in;
   assign isLoad  = mem_read_in & ~mem_write_in;

   // Addresses below the base wrap to a huge word index, so the explicit below-base test is kept
   // alongside the range test to make the intent obvious.
   assign wordIdx       = (alu_result_in - BASE_ADDR) >> 2;
   assign memIdx        = wordIdx[IDX_W-1:0];
   assign accessIllegal = (alu_result_in < BASE_ADDR) | (wordIdx >= DEPTH_WORDS) |
                          (alu_result_in[1:0] != 2'b00);

   // The stage only holds the pipeline while a memory access has not reached its final cycle.
   assign ready = ~memReq | (state_q == DONE);

   // Illegal accesses and non-loads return zero so nothing stale leaks into writeback.
   assign readData_d = (isLoad & ~accessIllegal) ? memArray[memIdx] : 32'h0;

   // Wait-state sequencer: IDLE -> (BUSY for WAIT_CYCLES cycles) -> DONE -> IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (memReq) begin
                  if (WAIT_CYCLES == 0) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= BUSY;
                     cnt_q   <= '0;
                  end
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Stores commit only on the edge that closes the DONE cycle, and never for illegal addresses.
   always_ff @(posedge clk) begin
      if (rst && (state_q == DONE) && mem_write_in && !accessIllegal) begin
         memArray[memIdx] <= val_rm_in;
      end
   end

   // MEM/WB register: capture the instruction when the stage is ready, otherwise insert a bubble.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_en_out      <= 1'b0;
         mem_read_out   <= 1'b0;
         dest_out       <= 4'h0;
         alu_result_out <= 32'h0;
         mem_data_out   <= 32'h0;
         addr_error_out <= 1'b0;
      end else if (ready) begin
         wb_en_out      <= wb_en_in;
         mem_read_out   <= isLoad;
         dest_out       <= dest_in;
         alu_result_out <= alu_result_in;
         mem_data_out   <= readData_d;
         addr_error_out <= memReq & accessIllegal;
      end else begin
         wb_en_out      <= 1'b0;
         mem_read_out   <= 1'b0;
         addr_error_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: randomized self-checking bench for the MEM stage. A word-array model of
// the data memory plus the address/stall rules predicts every MEM/WB result.
module tb_mem_stage_sram;

   localparam int BASE        = 1024;
   localparam int DEPTH       = 64;
   localparam int WAITS       = 2;
   localparam int STALL_LIMIT = 40;

   typedef struct packed {
      logic        wb;
      logic        rd;
      logic        err;
      logic [3:0]  dest;
      logic [31:0] alu;
      logic [31:0] data;
   } stageOutT;

   logic clk = 1'b0;
   logic rstMain, rstZero, useZero;
   logic memReadIn, memWriteIn, wbEnIn;
   logic [3:0]  destIn;
   logic [31:0] aluIn, valIn;

   logic        readyMain, wbMain, rdMain, errMain;
   logic [3:0]  destMain;
   logic [31:0] aluMain, dataMain;
   logic        readyZero, wbZero, rdZero, errZero;
   logic [3:0]  destZero;
   logic [31:0] aluZero, dataZero;

   stageOutT obs;
   logic     obsReady;

   int checks = 0;
   int errors = 0;

   logic [31:0] refMem     [DEPTH];
   logic [31:0] refMemZero [DEPTH];

   always #5 clk = ~clk;

   mem_stage_sram #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
      .clk(clk), .rst(rstMain),
      .mem_read_in(memReadIn), .mem_write_in(memWriteIn), .wb_en_in(wbEnIn),
      .dest_in(destIn), .alu_result_in(aluIn), .val_rm_in(valIn),
      .ready(readyMain), .wb_en_out(wbMain), .mem_read_out(rdMain), .dest_out(destMain),
      .alu_result_out(aluMain), .mem_data_out(dataMain), .addr_error_out(errMain)
   );

   mem_stage_sram #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dutZero (
      .clk(clk), .rst(rstZero),
      .mem_read_in(memReadIn), .mem_write_in(memWriteIn), .wb_en_in(wbEnIn),
      .dest_in(destIn), .alu_result_in(aluIn), .val_rm_in(valIn),
      .ready(readyZero), .wb_en_out(wbZero), .mem_read_out(rdZero), .dest_out(destZero),
      .alu_result_out(aluZero), .mem_data_out(dataZero), .addr_error_out(errZero)
   );

   // Observe whichever instance the current test is exercising.
   assign obs      = useZero ? {wbZero, rdZero, errZero, destZero, aluZero, dataZero}
                             : {wbMain, rdMain, errMain, destMain, aluMain, dataMain};
   assign obsReady = useZero ? readyZero : readyMain;

   // Guard against a hung run.
   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: simulation did not finish, limit 400000 time units");
      $fatal(1, "[TB] timeout");
   end

   task automatic idleInputs();
      memReadIn  = 1'b0;
      memWriteIn = 1'b0;
      wbEnIn     = 1'b0;
      destIn     = 4'h0;
      aluIn      = 32'h0;
      valIn      = 32'h0;
   endtask

   task automatic idleCycles(input int n);
      idleInputs();
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: an instruction stalls for the wait states plus one when it touches memory,
   // reads the word array for legal loads and updates it for legal stores.
   task automatic predict(input logic rd, input logic wr, input logic wb, input logic [3:0] dest,
                          input logic [31:0] alu, input logic [31:0] val,
                          output int expStall, output stageOutT expOut);
      longint unsigned addr;
      bit req, load, legal;
      int word, waits;
      addr  = alu;
      req   = rd | wr;
      load  = rd & !wr;
      legal = (addr >= BASE) && (addr < BASE + 4 * DEPTH) && (addr % 4 == 0);
      word  = legal ? int'((addr - BASE) / 4) : 0;
      waits = useZero ? 0 : WAITS;
      expStall    = req ? waits + 1 : 0;
      expOut.wb   = wb;
      expOut.rd   = load;
      expOut.err  = req && !legal;
      expOut.dest = dest;
      expOut.alu  = alu;
      expOut.data = (load && legal) ? (useZero ? refMemZero[word] : refMem[word]) : 32'h0;
      if (wr && legal) begin
         if (useZero) refMemZero[word] = val;
         else         refMem[word]     = val;
      end
   endtask

   // Present one instruction, hold it through the stall, and return once it has been captured.
   task automatic applyStimulus(input logic rd, input logic wr, input logic wb, input logic [3:0] dest,
                                input logic [31:0] alu, input logic [31:0] val,
                                output int stall, output logic bubbleOk);
      memReadIn  = rd;
      memWriteIn = wr;
      wbEnIn     = wb;
      destIn     = dest;
      aluIn      = alu;
      valIn      = val;
      stall      = 0;
      bubbleOk   = 1'b1;
      @(negedge clk);
      while (obsReady !== 1'b1 && stall < STALL_LIMIT) begin
         stall++;
         @(negedge clk);
         if (obs.wb !== 1'b0 || obs.rd !== 1'b0 || obs.err !== 1'b0) bubbleOk = 1'b0;
      end
      @(posedge clk);
      #1;
      idleInputs();
   endtask

   function automatic logic [31:0] legalAddr(input int word);
      return 32'(BASE + 4 * word);
   endfunction

   function automatic logic [31:0] pickAddr();
      case ($urandom_range(0, 9))
         0:       return 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
         1:       return 32'(BASE - 4 * $urandom_range(1, 8));
         2:       return 32'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 8));
         default: return legalAddr($urandom_range(0, DEPTH - 1));
      endcase
   endfunction

   task automatic test_fill();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      for (int i = 0; i < DEPTH; i++) begin
         logic [31:0] v;
         logic [3:0]  d;
         v = $urandom();
         d = 4'($urandom());
         predict(1'b0, 1'b1, 1'b0, d, legalAddr(i), v, expStall, expOut);
         applyStimulus(1'b0, 1'b1, 1'b0, d, legalAddr(i), v, stall, bubbleOk);
         checks++;
         if (stall !== expStall) begin
            errors++;
            $display("[TB] FAIL fill_stall word %0d: got %0d cycles, expected %0d", i, stall, expStall);
         end
         checks++;
         if (obs !== expOut) begin
            errors++;
            $display("[TB] FAIL fill_out word %0d: got %h expected %h", i, obs, expOut);
         end
      end
   endtask

   task automatic test_reset();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      logic [31:0] target;
      target     = legalAddr(5);
      memReadIn  = 1'b0;
      memWriteIn = 1'b1;
      wbEnIn     = 1'b1;
      destIn     = 4'hA;
      aluIn      = target;
      valIn      = ~refMem[5];
      rstMain    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected all zero", obs);
      end
      @(posedge clk);
      #1;
      rstMain = 1'b1;
      idleInputs();
      predict(1'b1, 1'b0, 1'b1, 4'h2, target, 32'h0, expStall, expOut);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'h2, target, 32'h0, stall, bubbleOk);
      checks++;
      if (stall !== expStall) begin
         errors++;
         $display("[TB] FAIL reset_idle_stall: got %0d cycles, expected %0d", stall, expStall);
      end
      checks++;
      if (obs.data !== expOut.data) begin
         errors++;
         $display("[TB] FAIL reset_no_write: got %h expected %h", obs.data, expOut.data);
      end
   endtask

   task automatic test_alu();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      for (int i = 0; i < 8; i++) begin
         logic wb;
         logic [3:0] d;
         logic [31:0] a;
         wb = (i == 0) ? 1'b1 : 1'($urandom());
         d  = (i == 0) ? 4'd3 : 4'($urandom());
         a  = (i == 0) ? 32'h55 : $urandom();
         predict(1'b0, 1'b0, wb, d, a, $urandom(), expStall, expOut);
         applyStimulus(1'b0, 1'b0, wb, d, a, $urandom(), stall, bubbleOk);
         checks++;
         if (stall !== expStall) begin
            errors++;
            $display("[TB] FAIL alu_stall %0d: got %0d cycles, expected %0d", i, stall, expStall);
         end
         checks++;
         if (obs !== expOut) begin
            errors++;
            $display("[TB] FAIL alu_out %0d: got %h expected %h", i, obs, expOut);
         end
      end
   endtask

   task automatic test_store();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      predict(1'b0, 1'b1, 1'b1, 4'h7, 32'd1028, 32'hDEADBEEF, expStall, expOut);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'h7, 32'd1028, 32'hDEADBEEF, stall, bubbleOk);
      checks++;
      if (stall !== expStall) begin
         errors++;
         $display("[TB] FAIL store_stall: got %0d cycles, expected %0d", stall, expStall);
      end
      checks++;
      if (bubbleOk !== 1'b1) begin
         errors++;
         $display("[TB] FAIL store_bubble: got bubble flag %b, expected 1", bubbleOk);
      end
      checks++;
      if (obs !== expOut) begin
         errors++;
         $display("[TB] FAIL store_out: got %h expected %h", obs, expOut);
      end
   endtask

   task automatic test_load_after_store();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      predict(1'b1, 1'b0, 1'b1, 4'h4, 32'd1028, 32'h0, expStall, expOut);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'h4, 32'd1028, 32'h0, stall, bubbleOk);
      checks++;
      if (stall !== expStall) begin
         errors++;
         $display("[TB] FAIL load_stall: got %0d cycles, expected %0d", stall, expStall);
      end
      checks++;
      if (obs.rd !== 1'b1 || obs.data !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL load_data: got rd=%b data=%h, expected rd=1 data=deadbeef", obs.rd, obs.data);
      end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, v;
         a = legalAddr($urandom_range(0, DEPTH - 1));
         v = $urandom();
         predict(1'b0, 1'b1, 1'b0, 4'h1, a, v, expStall, expOut);
         applyStimulus(1'b0, 1'b1, 1'b0, 4'h1, a, v, stall, bubbleOk);
         predict(1'b1, 1'b0, 1'b1, 4'h9, a, 32'h0, expStall, expOut);
         applyStimulus(1'b1, 1'b0, 1'b1, 4'h9, a, 32'h0, stall, bubbleOk);
         checks++;
         if (obs !== expOut || stall !== expStall) begin
            errors++;
            $display("[TB] FAIL st_ld_pair %0d: got %h stall %0d, expected %h stall %0d",
                     i, obs, stall, expOut, expStall);
         end
      end
   endtask

   task automatic test_illegal();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      logic [31:0] bad [3];
      logic [31:0] probe [3];
      bad[0]   = 32'd1026;
      bad[1]   = 32'd1020;
      bad[2]   = 32'(BASE + 4 * DEPTH);
      probe[0] = legalAddr(0);
      probe[1] = legalAddr(DEPTH - 1);
      probe[2] = legalAddr(1);
      for (int i = 0; i < 3; i++) begin
         predict(1'b1, 1'b0, 1'b1, 4'h6, bad[i], 32'h0, expStall, expOut);
         applyStimulus(1'b1, 1'b0, 1'b1, 4'h6, bad[i], 32'h0, stall, bubbleOk);
         checks++;
         if (obs !== expOut || stall !== expStall) begin
            errors++;
            $display("[TB] FAIL illegal_load %h: got %h stall %0d, expected %h stall %0d",
                     bad[i], obs, stall, expOut, expStall);
         end
         predict(1'b0, 1'b1, 1'b0, 4'h6, bad[i], 32'hA5A5_0000 + i, expStall, expOut);
         applyStimulus(1'b0, 1'b1, 1'b0, 4'h6, bad[i], 32'hA5A5_0000 + i, stall, bubbleOk);
         checks++;
         if (obs !== expOut) begin
            errors++;
            $display("[TB] FAIL illegal_store %h: got %h expected %h", bad[i], obs, expOut);
         end
      end
      for (int i = 0; i < 3; i++) begin
         predict(1'b1, 1'b0, 1'b1, 4'h8, probe[i], 32'h0, expStall, expOut);
         applyStimulus(1'b1, 1'b0, 1'b1, 4'h8, probe[i], 32'h0, stall, bubbleOk);
         checks++;
         if (obs !== expOut) begin
            errors++;
            $display("[TB] FAIL illegal_untouched %h: got %h expected %h", probe[i], obs, expOut);
         end
      end
   endtask

   task automatic test_random();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      for (int i = 0; i < 60; i++) begin
         logic rd, wr, wb;
         logic [3:0] d;
         logic [31:0] a, v;
         int kind;
         kind = $urandom_range(0, 3);
         rd = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
         wr = (kind == 2) || (kind == 3);
         wb = 1'($urandom());
         d  = 4'($urandom());
         a  = (kind == 0) ? $urandom() : pickAddr();
         v  = $urandom();
         predict(rd, wr, wb, d, a, v, expStall, expOut);
         applyStimulus(rd, wr, wb, d, a, v, stall, bubbleOk);
         checks++;
         if (stall !== expStall || bubbleOk !== 1'b1) begin
            errors++;
            $display("[TB] FAIL random_stall %0d: got %0d cycles bubble %b, expected %0d bubble 1",
                     i, stall, bubbleOk, expStall);
         end
         checks++;
         if (obs !== expOut) begin
            errors++;
            $display("[TB] FAIL random_out %0d: got %h expected %h", i, obs, expOut);
         end
         if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
      end
   endtask

   task automatic test_reset_busy();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      logic [31:0] target;
      target     = legalAddr(7);
      memReadIn  = 1'b0;
      memWriteIn = 1'b1;
      wbEnIn     = 1'b1;
      destIn     = 4'hC;
      aluIn      = target;
      valIn      = ~refMem[7];
      @(posedge clk);
      #1;
      rstMain = 1'b0;
      @(posedge clk);
      #1;
      rstMain = 1'b1;
      idleInputs();
      @(negedge clk);
      checks++;
      if (obsReady !== 1'b1 || obs !== '0) begin
         errors++;
         $display("[TB] FAIL busy_reset_state: got ready=%b out=%h, expected ready=1 out=0", obsReady, obs);
      end
      @(posedge clk);
      #1;
      predict(1'b1, 1'b0, 1'b1, 4'h2, target, 32'h0, expStall, expOut);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'h2, target, 32'h0, stall, bubbleOk);
      checks++;
      if (stall !== expStall || obs !== expOut) begin
         errors++;
         $display("[TB] FAIL busy_reset_no_write: got %h stall %0d, expected %h stall %0d",
                  obs, stall, expOut, expStall);
      end
   endtask

   task automatic test_wait0();
      int stall, expStall;
      stageOutT expOut;
      logic bubbleOk;
      logic rdT [6];
      logic wrT [6];
      logic [31:0] addrT [6];
      int w1, w2;
      w1 = $urandom_range(0, DEPTH - 1);
      w2 = (w1 + 1) % DEPTH;
      rdT = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      wrT = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      addrT[0] = legalAddr(w1);
      addrT[1] = legalAddr(w1);
      addrT[2] = legalAddr(w2);
      addrT[3] = 32'd1026;
      addrT[4] = legalAddr(w2);
      addrT[5] = 32'h1234;
      useZero = 1'b1;
      rstMain = 1'b0;
      rstZero = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic [31:0] v;
         v = $urandom();
         predict(rdT[i], wrT[i], 1'b1, 4'(i), addrT[i], v, expStall, expOut);
         applyStimulus(rdT[i], wrT[i], 1'b1, 4'(i), addrT[i], v, stall, bubbleOk);
         checks++;
         if (stall !== expStall) begin
            errors++;
            $display("[TB] FAIL wait0_stall %0d: got %0d cycles, expected %0d", i, stall, expStall);
         end
         checks++;
         if (obs !== expOut) begin
            errors++;
            $display("[TB] FAIL wait0_out %0d: got %h expected %h", i, obs, expOut);
         end
      end
   endtask

   initial begin
      rstMain = 1'b0;
      rstZero = 1'b0;
      useZero = 1'b0;
      idleInputs();
      repeat (2) @(posedge clk);
      #1;
      rstMain = 1'b1;
      $display("[TB] starting MEM stage tests");
      test_fill();
      test_reset();
      test_alu();
      test_store();
      test_load_after_store();
      test_illegal();
      test_random();
      test_reset_busy();
      test_wait0();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
